uart_slave_rx: RTL and testbench
================================

Name: uart_slave_rx

Overview:
- UART receiver. It is the receive end of the team's UART link: 1 start bit (0), DATA_BITS data bits LSB first, optional even-parity bit, then 1 stop bit (1).
- Oversamples the serial line u_rx using CLKS_PER_BIT clocks per bit and samples each bit at mid-bit.
- Delivers the byte on rx_data with a one-cycle u_rx_done pulse and per-frame error flags.
- Sits between the serial pin and the main bus or consumer module.

Parameters:
- CLKS_PER_BIT, 16, clocks per serial bit. Must be ≥4 and even.
- DATA_BITS, 8, data bits per frame, range 5..8.
- PARITY_EN, 1: 1 = even-parity bit present; 0 = no parity bit.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- u_rx  input  1  serial line from the remote UART. Idle is high; the pull-up resolves z to 1 at the board level.
- en_rx  input  1  receive enable; gates start-bit detection only.
- rx_data  output  DATA_BITS  last received data word.
- u_rx_done  output  1  one-cycle pulse when a frame completes.
- rx_parity_err  output  1  parity mismatch on the last frame.
- rx_frame_err  output  1  stop bit sampled 0 on the last frame.
- rx_busy  output  1  high while in any state other than IDLE.

Behaviour:
- Input path: u_rx passes through a 2-flop synchronizer (reset value 1). All decisions use the synchronized value rxs.
- Reset: state=IDLE, counters=0, rx_data=0, u_rx_done=0, rx_parity_err=0, rx_frame_err=0, rx_busy=0, shift register=0. This applies mid-frame too; the partial frame is discarded with no done pulse.
- Line-armed flag: cleared on reset and on any frame that ends with rxs=0. Set when rxs=1 in IDLE. A start is only detected when the flag is set, so a held-low break never retriggers.
- States:
  - IDLE: if en_rx & armed & rxs==0, go to START with baud counter cleared.
  - START: count to CLKS_PER_BIT/2-1, then re-sample. If rxs==1 it is a false start: go to IDLE, no pulse, no flag change. Otherwise clear the counter and bit index and go to DATA.
  - DATA: every CLKS_PER_BIT clocks, sample rxs into shift-register bit[index], LSB first. After bit DATA_BITS-1, go to PARITY if PARITY_EN, else STOP.
  - PARITY: after CLKS_PER_BIT clocks, sample p and store perr = p ^ (XOR of data bits). Go to STOP.
  - STOP: after CLKS_PER_BIT clocks, sample s and store ferr = ~s. Go to DONE.
  - DONE: one cycle. rx_data <= shift register; rx_parity_err <= perr (0 if PARITY_EN=0); rx_frame_err <= ferr; u_rx_done=1. Go to IDLE.
- Latency: u_rx_done rises 1 clock after the stop-bit mid-sample. From the u_rx falling edge that is 2 + CLKS_PER_BIT/2 + (DATA_BITS+PARITY_EN+1)·CLKS_PER_BIT + 1 clocks (±1 for edge alignment).
- rx_data and both error flags hold until the next DONE. Data is still delivered when rx_parity_err or rx_frame_err is set.
- en_rx deasserted mid-frame: the frame completes normally. en_rx is only checked in IDLE.
- Back-to-back frames: a start bit that immediately follows a valid stop bit is detected. IDLE is re-entered 1 clock after DONE; the remaining stop-bit half-period keeps rxs=1, which re-arms.
- No FIFO. The consumer must take rx_data before the next u_rx_done; later frames overwrite it.

Test Plan:
- Frame 0xA5, parity 0, stop 1, CLKS_PER_BIT=16 → one u_rx_done pulse exactly 1 cycle wide, rx_data=0xA5, both error flags 0, pulse within 2+8+160+1 ±1 clocks of the start edge.
- Frame 0x01 with parity bit driven 0 (correct value is 1) → rx_data=0x01, rx_parity_err=1, rx_frame_err=0. Next frame 0x01 with parity 1 → rx_parity_err=0.
- Frame 0x3C with stop bit 0, then line held low 400 clocks → rx_frame_err=1, rx_data=0x3C, exactly one u_rx_done. Release high, send 0x7E → received, rx_frame_err=0.
- Low glitch of 4 clocks on idle line → no u_rx_done, rx_busy returns 0 within CLKS_PER_BIT/2+3 clocks, rx_data unchanged.
- rst pulsed during data bit 3 of 0xFF → all outputs 0 the following cycle, no done pulse. Following clean frame 0x5A → rx_data=0x5A.
- Back-to-back 0x00 then 0xFF with no idle gap → two done pulses, with values 0x00 then 0xFF. Frame 0x42 sent with en_rx=0 throughout → no done pulse.

Source files
------------

// File: rtl/uart_slave_rx.sv
// uart_slave_rx: oversampling UART receiver.
// Frame format: start(0), DATA_BITS data bits LSB first, optional even-parity bit, stop(1).
// The line is synchronized, and every bit is sampled once near its middle.
// The received word and its error flags are registered together with a one-cycle done pulse.
module uart_slave_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 u_rx,
  input  logic                 en_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 u_rx_done,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  // Registered state
  logic                 r_sync1;
  logic                 r_sync2;
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_armed;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_done;
  logic                 r_perr_out;
  logic                 r_ferr_out;

  // Next-state values
  state_t               w_state_next;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [IDX_W-1:0]     w_idx_next;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 w_perr_next;
  logic                 w_ferr_next;
  logic                 w_armed_next;
  logic                 w_sample_data;
  logic                 w_load_out;
  logic                 w_rxs;
  logic                 w_bit_end;

  assign w_rxs     = r_sync2;
  assign w_bit_end = (r_cnt == BIT_LAST);

  // Each shift-register bit captures the line only when its own index is being sampled.
  generate
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
      assign w_shift_next[gi] = (w_sample_data && (r_idx == IDX_W'(gi))) ? w_rxs : r_shift[gi];
    end
  endgenerate

  // Two-flop synchronizer on the asynchronous serial input; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= u_rx;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state and datapath decisions for the frame receiver.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_idx_next    = r_idx;
    w_perr_next   = r_perr;
    w_ferr_next   = r_ferr;
    w_armed_next  = r_armed;
    w_sample_data = 1'b0;
    w_load_out    = 1'b0;

    case (r_state)
      S_IDLE: begin
        // A high line re-arms start detection; a held-low break never does.
        if (w_rxs) begin
          w_armed_next = 1'b1;
        end
        if (en_rx && r_armed && !w_rxs) begin
          w_state_next = S_START;
          w_cnt_next   = '0;
        end
      end

      S_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_next = '0;
          if (w_rxs) begin
            // Line went back high before mid-start: treat as a glitch.
            w_state_next = S_IDLE;
          end else begin
            w_idx_next   = '0;
            w_state_next = S_DATA;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          w_sample_data = 1'b1;
          w_cnt_next    = '0;
          if (r_idx == IDX_LAST) begin
            w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      S_PARITY: begin
        if (w_bit_end) begin
          // Even parity: the parity bit plus all data bits must XOR to zero.
          w_perr_next  = w_rxs ^ (^r_shift);
          w_cnt_next   = '0;
          w_state_next = S_STOP;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          w_ferr_next = ~w_rxs;
          if (!w_rxs) begin
            w_armed_next = 1'b0;
          end
          w_cnt_next   = '0;
          w_state_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      S_DONE: begin
        w_load_out   = 1'b1;
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // State, counters and frame-local registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_perr  <= w_perr_next;
      r_ferr  <= w_ferr_next;
      r_armed <= w_armed_next;
    end
  end

  // Output registers: word and flags update together with the done pulse and then hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data     <= '0;
      r_done     <= 1'b0;
      r_perr_out <= 1'b0;
      r_ferr_out <= 1'b0;
    end else begin
      r_done <= w_load_out;
      if (w_load_out) begin
        r_data     <= r_shift;
        r_perr_out <= (PARITY_EN != 0) ? r_perr : 1'b0;
        r_ferr_out <= r_ferr;
      end
    end
  end

  assign rx_data       = r_data;
  assign u_rx_done     = r_done;
  assign rx_parity_err = r_perr_out;
  assign rx_frame_err  = r_ferr_out;
  assign rx_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_slave_rx.sv
// tb_uart_slave_rx: directed frames against a frame-level scoreboard model.
module tb_uart_slave_rx;

  localparam int CLKS = 16;
  localparam int DB   = 8;
  localparam int PE   = 1;
  localparam int HALF = CLKS / 2;
  localparam int LAT  = 2 + HALF + (DB + PE + 1) * CLKS + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          u_rx = 1'b1;
  logic          en_rx = 1'b1;
  logic [DB-1:0] rx_data;
  logic          u_rx_done;
  logic          rx_parity_err;
  logic          rx_frame_err;
  logic          rx_busy;

  uart_slave_rx #(
    .CLKS_PER_BIT(CLKS),
    .DATA_BITS   (DB),
    .PARITY_EN   (PE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .u_rx         (u_rx),
    .en_rx        (en_rx),
    .rx_data      (rx_data),
    .u_rx_done    (u_rx_done),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int done_count = 0;
  int exp_count = 0;

  typedef struct {
    logic [DB-1:0] d;
    logic          perr;
    logic          ferr;
    int            t0;
  } exp_t;

  exp_t exp_q[$];

  // Model of the registered outputs, updated when a frame is delivered.
  logic [DB-1:0] m_data = '0;
  logic          m_perr = 1'b0;
  logic          m_ferr = 1'b0;
  logic          prev_done = 1'b0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Compare process: every cycle outside reset the outputs must match the model.
  always @(negedge clk) begin
    if (!rst) begin
      if (u_rx_done) begin
        done_count++;
        check("done_width", {31'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got data %0h, no frame was expected", rx_data);
        end else begin
          exp_t e;
          int lat;
          e   = exp_q.pop_front();
          lat = cyc - e.t0;
          $display("frame: data=%02h perr=%0b ferr=%0b latency=%0d (expected %02h %0b %0b)",
                   rx_data, rx_parity_err, rx_frame_err, lat, e.d, e.perr, e.ferr);
          check("frame_data", {24'd0, rx_data}, {24'd0, e.d});
          check("frame_perr", {31'd0, rx_parity_err}, {31'd0, e.perr});
          check("frame_ferr", {31'd0, rx_frame_err}, {31'd0, e.ferr});
          check("latency_window", {31'd0, (lat >= LAT - 1 && lat <= LAT + 1)}, 32'd1);
          m_data = e.d;
          m_perr = e.perr;
          m_ferr = e.ferr;
        end
      end else begin
        check("hold", {22'd0, rx_data, rx_parity_err, rx_frame_err},
              {22'd0, m_data, m_perr, m_ferr});
      end
      prev_done = u_rx_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Drive one bit period; caller is positioned just after a rising edge.
  task automatic drive_bit(input logic b);
    u_rx = b;
    repeat (CLKS) @(posedge clk);
    #1;
  endtask

  // Send a complete frame; expect_rx says whether the receiver should take it.
  task automatic send_frame(input logic [DB-1:0] d, input logic p, input logic s, input bit expect_rx);
    if (expect_rx) begin
      exp_t e;
      e.d    = d;
      e.perr = p ^ (^d);
      e.ferr = ~s;
      e.t0   = cyc;
      exp_q.push_back(e);
      exp_count++;
    end
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    if (PE != 0) drive_bit(p);
    drive_bit(s);
  endtask

  task automatic idle(input int n);
    u_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    exp_q.delete();
    m_data = '0;
    m_perr = 1'b0;
    m_ferr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int k;
    int t_idle;
    int d0;
    bit saw_busy;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_data", {24'd0, rx_data}, 32'd0);
    check("reset_done", {31'd0, u_rx_done}, 32'd0);
    check("reset_perr", {31'd0, rx_parity_err}, 32'd0);
    check("reset_ferr", {31'd0, rx_frame_err}, 32'd0);
    check("reset_busy", {31'd0, rx_busy}, 32'd0);
    @(posedge clk);
    #1;
    idle(20);

    // Clean frame with correct parity.
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    check("a5_data", {24'd0, rx_data}, 32'h0000_00A5);
    check("a5_flags", {30'd0, rx_parity_err, rx_frame_err}, 32'd0);
    idle(10);

    // Wrong parity, then correct parity for the same word.
    send_frame(8'h01, 1'b0, 1'b1, 1'b1);
    check("p0_data", {24'd0, rx_data}, 32'h0000_0001);
    check("p0_perr", {31'd0, rx_parity_err}, 32'd1);
    check("p0_ferr", {31'd0, rx_frame_err}, 32'd0);
    idle(10);
    send_frame(8'h01, 1'b1, 1'b1, 1'b1);
    check("p1_perr", {31'd0, rx_parity_err}, 32'd0);
    idle(10);

    // Stop bit low followed by a long break: one delivery, no retrigger.
    d0 = done_count;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    u_rx = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    check("brk_ferr", {31'd0, rx_frame_err}, 32'd1);
    check("brk_data", {24'd0, rx_data}, 32'h0000_003C);
    check("brk_one_done", done_count - d0, 32'd1);
    idle(20);
    send_frame(8'h7E, 1'b0, 1'b1, 1'b1);
    check("7e_data", {24'd0, rx_data}, 32'h0000_007E);
    check("7e_ferr", {31'd0, rx_frame_err}, 32'd0);
    idle(10);

    // Short low glitch on an idle line.
    d0 = done_count;
    k = cyc;
    t_idle = -1;
    saw_busy = 1'b0;
    fork
      begin
        u_rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        u_rx = 1'b1;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (rx_busy) saw_busy = 1'b1;
          else if (saw_busy && t_idle < 0) t_idle = cyc - k;
        end
      end
    join
    @(posedge clk);
    #1;
    check("glitch_busy_seen", {31'd0, saw_busy}, 32'd1);
    check("glitch_busy_clear", {31'd0, (t_idle >= 0 && t_idle <= HALF + 3)}, 32'd1);
    check("glitch_no_done", done_count - d0, 32'd0);
    check("glitch_data", {24'd0, rx_data}, 32'h0000_007E);
    idle(10);

    // Reset in the middle of data bit 3 of 0xFF.
    d0 = done_count;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    u_rx = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
    pulse_reset();
    @(negedge clk);
    check("rst_mid_data", {24'd0, rx_data}, 32'd0);
    check("rst_mid_flags", {29'd0, u_rx_done, rx_parity_err, rx_frame_err}, 32'd0);
    check("rst_mid_busy", {31'd0, rx_busy}, 32'd0);
    @(posedge clk);
    #1;
    idle(200);
    check("rst_no_done", done_count - d0, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    check("5a_data", {24'd0, rx_data}, 32'h0000_005A);
    idle(10);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b0, 1'b1, 1'b1);
    check("b2b_first", {24'd0, rx_data}, 32'h0000_0000);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
    check("b2b_second", {24'd0, rx_data}, 32'h0000_00FF);
    idle(10);

    // Receiver disabled for a whole frame.
    d0 = done_count;
    en_rx = 1'b0;
    send_frame(8'h42, 1'b0, 1'b1, 1'b0);
    idle(20);
    en_rx = 1'b1;
    check("dis_no_done", done_count - d0, 32'd0);
    check("dis_data", {24'd0, rx_data}, 32'h0000_00FF);

    idle(50);
    check("queue_empty", exp_q.size(), 32'd0);
    check("done_total", done_count, exp_count);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
